// File: rtl/wbarbiter2.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for a whole
// bus cycle, plus a per-grant watchdog that answers a hung strobe with err.
module wbarbiter2 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_ni,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state;
    logic            last;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_upd;
    logic            gnt0;
    logic            gnt1;
    logic            gnt_stb;
    logic            timeout_hit;

    assign gnt0        = (state == GNT0);
    assign gnt1        = (state == GNT1);
    assign gnt_stb     = (gnt0 & m0_cyc_i & m0_stb_i) | (gnt1 & m1_cyc_i & m1_stb_i);
    // An ack arriving on the final watchdog cycle takes precedence over err.
    assign timeout_hit = gnt_stb & (cnt == CW'(TIMEOUT)) & ~s_ack_i;

    // Watchdog counts only while the granted strobe waits unacknowledged.
    always_comb begin
        cnt_upd = cnt;
        if (s_ack_i || !gnt_stb || timeout_hit)
            cnt_upd = '0;
        else if (cnt != CW'(TIMEOUT))
            cnt_upd = cnt + CW'(1);
    end

    // Grant FSM; leaving or changing a grant always restarts the watchdog.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_ni) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            cnt <= cnt_upd;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        cnt <= '0;
                        if (m1_cyc_i) begin
                            state <= GNT1;
                            last  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        cnt <= '0;
                        if (m0_cyc_i) begin
                            state <= GNT0;
                            last  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave request mux; IDLE presents master 0's payload with cyc/stb low.
    always_comb begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_cyc_o = 1'b0;
        if (gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_cyc_o = m1_cyc_i;
        end else if (gnt0) begin
            s_cyc_o = m0_cyc_i;
        end
        s_stb_o = gnt_stb & ~timeout_hit;
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & gnt0;
    assign m1_ack_o = s_ack_i & gnt1;
    assign m0_err_o = timeout_hit & gnt0;
    assign m1_err_o = timeout_hit & gnt1;

endmodule
